ps2_rx_fifo: RTL and testbench

PS/2 keyboard receiver that sits between the board PS2Clk/PS2Data pins and the OTTER MMIO input bus inside OTTER_Wrapper. It synchronizes and de-glitches the PS/2 lines, deserializes 11-bit frames, and checks parity and stop bits. Good bytes are queued in a small FIFO, which the CPU reads through a pop strobe. An interrupt pulse is raised for each accepted byte.

---
 rtl/ps2_rx_fifo_pkg.sv | 14 +
 rtl/ps2_rx_fifo_if.sv | 24 ++
 rtl/ps2_rx_fifo_byte_fifo.sv | 57 +++++
 rtl/ps2_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_fifo_pkg.sv
// Shared PS/2 receiver definitions: frame constants and the deserializer state set.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// CPU-facing key register bus: pop/clear strobes in, head byte and status out.
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          RD;
  logic                          CLR;
  logic [7:0]                    DATA;
  logic                          VALID;
  logic [$clog2(FIFO_DEPTH):0]   COUNT;
  logic                          INTR;
  logic                          PAR_ERR;
  logic                          FRM_ERR;
  logic                          OVF;

  modport master (
    output RD, CLR,
    input  DATA, VALID, COUNT, INTR, PAR_ERR, FRM_ERR, OVF
  );

  modport slave (
    input  RD, CLR,
    output DATA, VALID, COUNT, INTR, PAR_ERR, FRM_ERR, OVF
  );
endinterface

// File: rtl/ps2_rx_fifo_byte_fifo.sv
// Small byte FIFO; a pop in the same cycle as a push to a full FIFO frees the slot first.
module ps2_byte_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_ok, push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? 8'h00 : mem_q[rd_q];
  assign count   = cnt_q;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage array carries data only, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronize, de-glitch, deserialize 11-bit frames, queue good bytes.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PS2Clk,
  input  logic          PS2Data,
  ps2_rx_fifo_if.slave  bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] fcnt_q;
  logic          fall;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d, pbyte_q, pbyte_d;
  logic          par_q, par_d;
  logic          push_q, push_d;
  logic          frm_set, par_set, ovf_set;
  logic          intr_q, par_err_q, frm_err_q, ovf_q;

  logic [7:0]    f_dout;
  logic          f_full, f_empty, accepted;

  // Two-flop synchronizers idle high like the open-collector PS/2 lines.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2Clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2Data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Filtered clock follows the synchronized level only after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s2_q != filt_q) begin
        if (fcnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q <= clk_s2_q;
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + FW'(1);
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // Frame deserializer with a mid-frame watchdog; the stop-bit Fall schedules the push one cycle later.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    pbyte_d = pbyte_q;
    push_d  = 1'b0;
    frm_set = 1'b0;
    par_set = 1'b0;
    tmo_d   = (state_q == ST_IDLE || fall) ? '0 : tmo_q + TW'(1);
    case (state_q)
      ST_IDLE: if (fall) begin
        if (!dat_s2_q) begin
          state_d = ST_DATA;
          bcnt_d  = 3'd0;
        end else begin
          frm_set = 1'b1;
        end
      end
      ST_DATA: if (fall) begin
        shift_d[bcnt_q] = dat_s2_q;
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = ST_PARITY;
      end
      ST_PARITY: if (fall) begin
        par_d   = dat_s2_q;
        state_d = ST_STOP;
      end
      ST_STOP: if (fall) begin
        state_d = ST_IDLE;
        if (!dat_s2_q) begin
          frm_set = 1'b1;
        end else if (^{shift_q, par_q} != 1'b1) begin
          par_set = 1'b1;
        end else begin
          push_d  = 1'b1;
          pbyte_d = shift_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      frm_set = 1'b1;
      tmo_d   = '0;
    end
  end

  // Control state of the deserializer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      bcnt_q  <= 3'd0;
      tmo_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      push_q  <= push_d;
    end
  end

  // Shift register, parity bit and pending byte are pure data.
  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    pbyte_q <= pbyte_d;
  end

  ps2_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push_q),
    .pop   (bus.RD),
    .din   (pbyte_q),
    .dout  (f_dout),
    .count (bus.COUNT),
    .full  (f_full),
    .empty (f_empty)
  );

  assign accepted = push_q & (~f_full | bus.RD);
  assign ovf_set  = push_q & f_full & ~bus.RD;

  // Interrupt pulse lands on the first cycle the new byte is visible; sticky flags let set beat clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      intr_q    <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      intr_q    <= accepted;
      par_err_q <= par_set | (par_err_q & ~bus.CLR);
      frm_err_q <= frm_set | (frm_err_q & ~bus.CLR);
      ovf_q     <= ovf_set | (ovf_q & ~bus.CLR);
    end
  end

  assign bus.DATA    = f_dout;
  assign bus.VALID   = ~f_empty;
  assign bus.INTR    = intr_q;
  assign bus.PAR_ERR = par_err_q;
  assign bus.FRM_ERR = frm_err_q;
  assign bus.OVF     = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for the PS/2 receiver FIFO with hand-computed expectations.
module tb_ps2_rx_fifo;
  localparam int HALF = 40;
  localparam int TMO  = 2000;

  logic CLK = 1'b0;
  logic RST_N;
  logic PS2Clk;
  logic PS2Data;
  int   errs = 0;
  int   checks = 0;
  int   intr_cnt = 0;
  int   intr_base;

  ps2_rx_fifo_if #(.FIFO_DEPTH(4)) bus ();

  ps2_rx_fifo #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .PS2Clk  (PS2Clk),
    .PS2Data (PS2Data),
    .bus     (bus)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.INTR === 1'b1) begin
      intr_cnt++;
      chk("intr_with_valid", 32'(bus.VALID), 32'd1);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par_ok);
    logic p;
    p = par_ok ? ~(^b) : (^b);
    return {1'b1, p, b, 1'b0};
  endfunction

  // Drive bits [first..last] of a frame, LSB (start bit) first; optional 3-cycle low glitch in one high phase.
  task automatic send_bits(input logic [10:0] f, input int first, input int last, input int glitch_at);
    for (int i = first; i <= last; i++) begin
      PS2Data = f[i];
      if (i == glitch_at) begin
        wait_clk(HALF / 2);
        PS2Clk = 1'b0;
        wait_clk(3);
        PS2Clk = 1'b1;
        wait_clk(HALF - HALF / 2 - 3);
      end else begin
        wait_clk(HALF);
      end
      PS2Clk = 1'b0;
      wait_clk(HALF);
      PS2Clk = 1'b1;
    end
    PS2Data = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok);
    send_bits(mk_frame(b, par_ok), 0, 10, -1);
  endtask

  task automatic pulse_rd();
    bus.RD = 1'b1;
    wait_clk(1);
    bus.RD = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.CLR = 1'b1;
    wait_clk(1);
    bus.CLR = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(bus.DATA),    32'd0);
    chk({tag, "_valid"}, 32'(bus.VALID),   32'd0);
    chk({tag, "_count"}, 32'(bus.COUNT),   32'd0);
    chk({tag, "_intr"},  32'(bus.INTR),    32'd0);
    chk({tag, "_par"},   32'(bus.PAR_ERR), 32'd0);
    chk({tag, "_frm"},   32'(bus.FRM_ERR), 32'd0);
    chk({tag, "_ovf"},   32'(bus.OVF),     32'd0);
  endtask

  logic [7:0] seq [5];

  initial begin
    seq[0] = 8'h1C; seq[1] = 8'h32; seq[2] = 8'h21; seq[3] = 8'h23; seq[4] = 8'h24;
    RST_N = 1'b0; PS2Clk = 1'b1; PS2Data = 1'b1; bus.RD = 1'b0; bus.CLR = 1'b0;
    wait_clk(5);
    chk_all_zero("reset");
    RST_N = 1'b1;
    wait_clk(5);

    // Single good frame, then pop.
    intr_base = intr_cnt;
    send_frame(8'h1C, 1'b1);
    chk("t1_valid", 32'(bus.VALID), 32'd1);
    chk("t1_data",  32'(bus.DATA),  32'h1C);
    chk("t1_count", 32'(bus.COUNT), 32'd1);
    chk("t1_intr",  32'(intr_cnt - intr_base), 32'd1);
    chk("t1_frm",   32'(bus.FRM_ERR), 32'd0);
    chk("t1_par",   32'(bus.PAR_ERR), 32'd0);
    pulse_rd();
    chk("t1_rd_valid", 32'(bus.VALID), 32'd0);
    chk("t1_rd_data",  32'(bus.DATA),  32'd0);
    pulse_rd();
    chk("t1_rd_empty_count", 32'(bus.COUNT), 32'd0);

    // Bad parity.
    intr_base = intr_cnt;
    send_frame(8'h1C, 1'b0);
    chk("t2_valid", 32'(bus.VALID), 32'd0);
    chk("t2_intr",  32'(intr_cnt - intr_base), 32'd0);
    chk("t2_par",   32'(bus.PAR_ERR), 32'd1);
    pulse_clr();
    chk("t2_clr",   32'(bus.PAR_ERR), 32'd0);

    // Overflow with five frames and no reads.
    intr_base = intr_cnt;
    for (int i = 0; i < 5; i++) begin
      send_frame(seq[i], 1'b1);
      if (i == 3) chk("t3_ovf_before", 32'(bus.OVF), 32'd0);
    end
    chk("t3_count", 32'(bus.COUNT), 32'd4);
    chk("t3_ovf",   32'(bus.OVF),   32'd1);
    chk("t3_intr",  32'(intr_cnt - intr_base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_pop%0d", i), 32'(bus.DATA), 32'(seq[i]));
      pulse_rd();
    end
    chk("t3_empty", 32'(bus.VALID), 32'd0);
    pulse_clr();
    chk("t3_ovf_clr", 32'(bus.OVF), 32'd0);

    // Truncated frame aborted by the watchdog, then a good frame.
    intr_base = intr_cnt;
    send_bits(mk_frame(8'h55, 1'b1), 0, 4, -1);
    chk("t4_frm_early", 32'(bus.FRM_ERR), 32'd0);
    wait_clk(TMO + 1000);
    chk("t4_frm",   32'(bus.FRM_ERR), 32'd1);
    chk("t4_valid", 32'(bus.VALID),   32'd0);
    send_frame(8'hF0, 1'b1);
    chk("t4_data",  32'(bus.DATA),  32'hF0);
    chk("t4_count", 32'(bus.COUNT), 32'd1);
    chk("t4_intr",  32'(intr_cnt - intr_base), 32'd1);
    pulse_rd();
    pulse_clr();

    // Clock glitches while idle and mid-frame are filtered out.
    PS2Clk = 1'b0;
    wait_clk(3);
    PS2Clk = 1'b1;
    wait_clk(50);
    chk("t5_idle_frm",   32'(bus.FRM_ERR), 32'd0);
    chk("t5_idle_valid", 32'(bus.VALID),   32'd0);
    send_bits(mk_frame(8'h32, 1'b1), 0, 10, 4);
    chk("t5_data",  32'(bus.DATA),    32'h32);
    chk("t5_count", 32'(bus.COUNT),   32'd1);
    chk("t5_frm",   32'(bus.FRM_ERR), 32'd0);
    chk("t5_par",   32'(bus.PAR_ERR), 32'd0);

    // Reset in the middle of a frame, with one byte still queued.
    send_bits(mk_frame(8'h1C, 1'b1), 0, 5, -1);
    RST_N = 1'b0;
    wait_clk(3);
    chk_all_zero("t6_rst");
    RST_N = 1'b1;
    wait_clk(3);
    intr_base = intr_cnt;
    send_bits(mk_frame(8'h1C, 1'b1), 6, 10, -1);
    wait_clk(TMO + 1000);
    chk("t6_nopush_valid", 32'(bus.VALID), 32'd0);
    chk("t6_nopush_intr",  32'(intr_cnt - intr_base), 32'd0);
    pulse_clr();
    send_frame(8'h1C, 1'b1);
    chk("t6_data",  32'(bus.DATA),  32'h1C);
    chk("t6_count", 32'(bus.COUNT), 32'd1);
    chk("t6_intr",  32'(intr_cnt - intr_base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
